alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- 32-bit integer ALU for the execute stage of the pipelined processor.
- Combinational `result`/`zero` serve same-cycle consumers such as branch compare and forwarding.
- A one-stage registered copy (`result_q`/`zero_q`/`out_valid`) feeds the EX/MEM boundary.
- Operand 1 always comes from rs; operand 2 comes from rt or the immediate; shift distance arrives on a separate port, normally wired to op2[5:0].

Parameters:
- WIDTH, 32, datapath width; all arithmetic rules below assume 32.
- OPW, 6, width of the operation code.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op1  input  32  operand 1 (rs)
- op2  input  32  operand 2 (rt or immediate)
- operation  input  6  operation select
- shift_amount  input  6  shift distance, unsigned 0..63
- in_valid  input  1  inputs carry a real instruction this cycle
- result  output  32  combinational result
- zero  output  1  combinational, 1 when result == 0
- div_by_zero  output  1  combinational, 1 when operation==3 and op2==0
- result_q  output  32  result registered on clk
- zero_q  output  1  zero registered on clk
- out_valid  output  1  in_valid registered on clk

Behaviour:
- Combinational path has no state; `result`/`zero`/`div_by_zero` settle in the same delta as any input change.
- Operation encoding (all wrap modulo 2^32):
  - 0 ADD: op1+op2
  - 1 SUB: op1-op2
  - 2 MUL: low 32 bits of the signed product
  - 3 DIV: signed quotient, truncated toward zero; op2==0 gives result 0 and div_by_zero=1; 0x80000000/-1 gives 0x80000000
  - 4 SLL: op1 << shift_amount
  - 5 SRL: op1 >> shift_amount, logical, zero-filled
  - 6 SLT: 1 if $signed(op1) < $signed(op2), else 0
  - 7 AND, 8 OR, 9 XOR, 10 NOR: bitwise
  - 11 SRA: arithmetic right shift of op1 by shift_amount, sign-filled
  - 12 LUI: {op2[15:0], 16'h0000}; op1 ignored
  - 13..63: result 0
- Shifts with shift_amount >= 32: SLL/SRL give 0; SRA gives all bits equal to op1[31].
- `zero` = (result == 0) for every operation, including undefined codes (zero=1 there).
- No overflow trap or flag; ADD/SUB/MUL silently wrap.
- Registered stage, on each rising clk edge:
  - reset=1: result_q=0, zero_q=1, out_valid=0.
  - otherwise: result_q<=result, zero_q<=zero, out_valid<=in_valid.
- Register latency is exactly 1 cycle. The registers update even when in_valid=0; consumers qualify with out_valid.
- Reset mid-operation clears only the registered stage; combinational outputs keep tracking inputs.
- Reset dominates: in_valid is ignored in the cycle reset=1.

Test Plan:
- op1=0, op2=1, shift=1, ops 0..12 → results in order: 1, FFFFFFFF, 0, 0, 0, 0, 1, 0, 1, 1, FFFFFFFE, 0, 00010000. zero=1 for MUL, DIV, SLL, SRL, AND and SRA.
- op1=2, op2=1 → ADD 3, SUB 1, MUL 2, DIV 2, SLL 4, SRL 1, SLT 0, AND 0, OR 3, XOR 3, NOR FFFFFFFC, SRA 1, LUI 00010000.
- op1=3, op2=2, shift=2 → ADD 5, SUB 1, MUL 6, DIV 1, SLL C, SRL 0, SLT 0, AND 2, OR 3, XOR 1, NOR FFFFFFFC, SRA 0, LUI 00020000.
- op1=-1000 (FFFFFC18), op2=4 → ADD FFFFFC1C, SUB FFFFFC14, MUL FFFFF060, DIV FFFFFF06, SLL FFFFC180, SRL 0FFFFFC1, SLT 1, AND 0, OR FFFFFC1C, XOR FFFFFC1C, NOR 000003E3, SRA FFFFFFC1, LUI 00040000.
- Edge cases:
  - DIV with op2=0 → result 0, div_by_zero=1.
  - op1=80000000, op2=FFFFFFFF, DIV → 80000000.
  - shift=40: SLL/SRL of FFFFFFFF → 0; SRA of 80000000 → FFFFFFFF.
  - operation=20 → result 0, zero=1.
- Registered stage:
  - Hold reset=1 for 2 cycles → result_q=0, zero_q=1, out_valid=0.
  - Release reset, apply ADD 2+1 with in_valid=1 → after one edge, result_q=3, zero_q=0, out_valid=1.
  - Assert reset on the next cycle → registers return to reset values at the following edge.

Source files
------------

// File: rtl/alu_unit.sv
// 32-bit execute-stage ALU: combinational result for same-cycle consumers
// plus a one-cycle registered copy for the EX/MEM boundary.
module alu_unit #(
  parameter int WIDTH = 32,
  parameter int OPW   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [OPW-1:0]   operation,
  input  logic [5:0]       shift_amount,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic             out_valid
);

  typedef enum logic [OPW-1:0] {
    OP_ADD = OPW'(0),
    OP_SUB = OPW'(1),
    OP_MUL = OPW'(2),
    OP_DIV = OPW'(3),
    OP_SLL = OPW'(4),
    OP_SRL = OPW'(5),
    OP_SLT = OPW'(6),
    OP_AND = OPW'(7),
    OP_OR  = OPW'(8),
    OP_XOR = OPW'(9),
    OP_NOR = OPW'(10),
    OP_SRA = OPW'(11),
    OP_LUI = OPW'(12)
  } alu_op_e;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0]   s1;
  logic signed [WIDTH-1:0]   s2;
  logic signed [2*WIDTH-1:0] prod;
  logic        [WIDTH-1:0]   quot;
  logic                      shift_big;

  assign s1        = $signed(op1);
  assign s2        = $signed(op2);
  assign prod      = s1 * s2;
  assign shift_big = 32'(shift_amount) >= 32'(WIDTH);

  // Signed quotient; zero divisor and the one overflowing pair are handled
  // explicitly so the result never depends on simulator/synthesis division corners.
  always_comb begin
    quot = '0;
    if (op2 == '0) begin
      quot = '0;
    end else if (op1 == MOST_NEG && op2 == '1) begin
      quot = MOST_NEG;
    end else begin
      quot = $unsigned(s1 / s2);
    end
  end

  // Operation select; undefined codes produce zero.
  always_comb begin
    result = '0;
    case (operation)
      OP_ADD: result = op1 + op2;
      OP_SUB: result = op1 - op2;
      OP_MUL: result = prod[WIDTH-1:0];
      OP_DIV: result = quot;
      OP_SLL: result = shift_big ? '0 : (op1 << shift_amount);
      OP_SRL: result = shift_big ? '0 : (op1 >> shift_amount);
      OP_SLT: result = {{(WIDTH-1){1'b0}}, (s1 < s2)};
      OP_AND: result = op1 & op2;
      OP_OR:  result = op1 | op2;
      OP_XOR: result = op1 ^ op2;
      OP_NOR: result = ~(op1 | op2);
      OP_SRA: result = shift_big ? {WIDTH{op1[WIDTH-1]}} : $unsigned(s1 >>> shift_amount);
      OP_LUI: result = WIDTH'(op2[15:0]) << 16;
      default: result = '0;
    endcase
  end

  // Status flags derived from the combinational result and inputs.
  always_comb begin
    zero        = (result == '0);
    div_by_zero = (operation == OP_DIV) && (op2 == '0);
  end

  // EX/MEM register; updates every cycle, consumers qualify with out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      result_q  <= result;
      zero_q    <= zero;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: driver pushes expected values, two
// monitors (combinational and registered) pop and compare.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [5:0]  operation;
  logic [5:0]  shift_amount;
  logic        in_valid;
  logic [31:0] result;
  logic        zero;
  logic        div_by_zero;
  logic [31:0] result_q;
  logic        zero_q;
  logic        out_valid;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        dbz;
    logic [5:0]  op;
  } comb_t;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        v;
  } reg_t;

  comb_t comb_q[$];
  reg_t  reg_q[$];

  alu_unit #(.WIDTH(32), .OPW(6)) dut (
    .clk(clk),
    .reset(reset),
    .op1(op1),
    .op2(op2),
    .operation(operation),
    .shift_amount(shift_amount),
    .in_valid(in_valid),
    .result(result),
    .zero(zero),
    .div_by_zero(div_by_zero),
    .result_q(result_q),
    .zero_q(zero_q),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit integer arithmetic, truncated to 32 bits at the end.
  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] op, input logic [5:0] sh);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      6'd0:  r = sa + sb;
      6'd1:  r = sa - sb;
      6'd2:  r = sa * sb;
      6'd3:  r = (sb == 0) ? 64'sd0 : sa / sb;
      6'd4:  r = ua << sh;
      6'd5:  r = ua >> sh;
      6'd6:  r = (sa < sb) ? 64'sd1 : 64'sd0;
      6'd7:  r = ua & ub;
      6'd8:  r = ua | ub;
      6'd9:  r = ua ^ ub;
      6'd10: r = ~(ua | ub);
      6'd11: r = sa >>> sh;
      6'd12: r = (ub % 65536) * 65536;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic drive(input logic rst, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] op, input logic [5:0] sh,
                       input logic use_k, input logic [31:0] k);
    comb_t c;
    reg_t  r;
    logic [31:0] e;
    @(negedge clk);
    reset        = rst;
    in_valid     = v;
    op1          = a;
    op2          = b;
    operation    = op;
    shift_amount = sh;
    e = use_k ? k : ref_model(a, b, op, sh);
    c.res = e;
    c.z   = (e == 32'd0);
    c.dbz = (op == 6'd3) && (b == 32'd0);
    c.op  = op;
    comb_q.push_back(c);
    if (rst) begin
      r.res = 32'd0;
      r.z   = 1'b1;
      r.v   = 1'b0;
    end else begin
      r.res = e;
      r.z   = (e == 32'd0);
      r.v   = v;
    end
    reg_q.push_back(r);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op,
                     input logic [5:0] sh);
    drive(1'b0, 1'b1, a, b, op, sh, 1'b0, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Combinational monitor: checks outputs shortly after each new input set.
  initial begin
    comb_t c;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        vectors++;
        if (result !== c.res) begin
          miscompares++;
          $display("FAIL result op=%0d op1=%h op2=%h sh=%0d: got %h expected %h",
                   c.op, op1, op2, shift_amount, result, c.res);
        end
        vectors++;
        if (zero !== c.z) begin
          miscompares++;
          $display("FAIL zero op=%0d: got %b expected %b", c.op, zero, c.z);
        end
        vectors++;
        if (div_by_zero !== c.dbz) begin
          miscompares++;
          $display("FAIL div_by_zero op=%0d op2=%h: got %b expected %b",
                   c.op, op2, div_by_zero, c.dbz);
        end
      end
    end
  end

  // Registered monitor: checks the stage one edge after each input set.
  initial begin
    reg_t r;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        r = reg_q.pop_front();
        vectors++;
        if (result_q !== r.res || zero_q !== r.z || out_valid !== r.v) begin
          miscompares++;
          $display("FAIL regstage: got q=%h z=%b v=%b expected q=%h z=%b v=%b",
                   result_q, zero_q, out_valid, r.res, r.z, r.v);
        end
      end
    end
  end

  logic [31:0] neg_row [13] = '{32'hFFFFFC1C, 32'hFFFFFC14, 32'hFFFFF060, 32'hFFFFFF06,
                                32'hFFFFC180, 32'h0FFFFFC1, 32'h00000001, 32'h00000000,
                                32'hFFFFFC1C, 32'hFFFFFC1C, 32'h000003E3, 32'hFFFFFFC1,
                                32'h00040000};

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    op1 = '0;
    op2 = '0;
    operation = '0;
    shift_amount = '0;

    // Reset held, release with ADD 2+1, reset again.
    drive(1'b1, 1'b1, 32'd7, 32'd5, 6'd0, 6'd0, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 32'd7, 32'd5, 6'd0, 6'd0, 1'b0, 32'd0);
    run(32'd2, 32'd1, 6'd0, 6'd1);
    drive(1'b1, 1'b1, 32'd2, 32'd1, 6'd0, 6'd1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd2, 32'd1, 6'd1, 6'd1, 1'b0, 32'd0);

    for (int op = 0; op < 13; op++) run(32'd0, 32'd1, 6'(op), 6'd1);
    for (int op = 0; op < 13; op++) run(32'd2, 32'd1, 6'(op), 6'd1);
    for (int op = 0; op < 13; op++) run(32'd3, 32'd2, 6'(op), 6'd2);
    for (int op = 0; op < 13; op++)
      drive(1'b0, 1'b1, 32'hFFFFFC18, 32'd4, 6'(op), 6'd4, 1'b1, neg_row[op]);

    // Boundaries.
    drive(1'b0, 1'b1, 32'd5, 32'd0, 6'd3, 6'd0, 1'b1, 32'd0);
    drive(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 6'd3, 6'd0, 1'b1, 32'h80000000);
    drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'd0, 6'd4, 6'd40, 1'b1, 32'd0);
    drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'd0, 6'd5, 6'd40, 1'b1, 32'd0);
    drive(1'b0, 1'b1, 32'h80000000, 32'd0, 6'd11, 6'd40, 1'b1, 32'hFFFFFFFF);
    drive(1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 6'd20, 6'd3, 1'b1, 32'd0);
    run(32'h7FFFFFFF, 32'hFFFFFFFF, 6'd11, 6'd63);
    run(32'h80000000, 32'h00000000, 6'd11, 6'd31);
    run(32'h80000000, 32'h00000001, 6'd6, 6'd0);

    // Random traffic, including undefined codes, stray resets and idle cycles.
    for (int i = 0; i < 600; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(13, 63)) : 6'($urandom_range(0, 12));
      drive(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), pick(), pick(), op,
            6'($urandom_range(0, 63)), 1'b0, 32'd0);
    end

    repeat (3) @(negedge clk);
    #3;
    vectors++;
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending entries expected 0/0", comb_q.size(), reg_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
